// File: rtl/fb_fetch.sv
// Framebuffer fetch engine: reads one pixel word at a time over Wishbone and
// buffers {sof, rgb} in a small FIFO that the video timing stage drains.
module fb_fetch #(
  parameter int          HDISP      = 800,
  parameter int          VDISP      = 480,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  output logic        wshb_cyc,
  output logic        wshb_stb,
  output logic        wshb_we,
  output logic [3:0]  wshb_sel,
  output logic [31:0] wshb_adr,
  input  logic [31:0] wshb_dat_sm,
  input  logic        wshb_ack,
  output logic [23:0] pix_rgb,
  output logic        pix_sof,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        underflow
);

  localparam int NPIX = HDISP * VDISP;
  localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;

  localparam logic [PW-1:0] LAST_IDX   = PW'(NPIX - 1);
  localparam logic [CW-1:0] FILL_LIMIT = CW'(FIFO_DEPTH - 2);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_started;
  logic          r_popped;
  logic          r_underflow;
  logic [PW-1:0] r_pix_idx;
  logic [31:0]   r_adr;
  logic [24:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_can_req;
  logic          w_sof;
  logic          w_unused;

  function automatic logic [CW-1:0] count_next(input logic          push,
                                               input logic          pop,
                                               input logic [CW-1:0] cnt);
    logic [CW-1:0] res;
    case ({push, pop})
      2'b10:   res = cnt + CW'(1);
      2'b01:   res = cnt - CW'(1);
      default: res = cnt;
    endcase
    return res;
  endfunction

  assign w_empty   = (r_count == CW'(0));
  assign w_push    = (r_state == S_REQ) && wshb_ack;
  assign w_pop     = !w_empty && pix_ready;
  // Two free entries are needed: one for the word about to be requested, one spare.
  assign w_can_req = (r_count <= FILL_LIMIT);
  assign w_sof     = (r_pix_idx == PW'(0));
  assign w_unused  = ^wshb_dat_sm[31:24];

  // FSM state register.
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; the first request waits one cycle after reset.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_started && w_can_req) begin
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        if (wshb_ack) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Start-up qualifier that holds off the first request after reset.
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      r_started <= 1'b0;
    end else begin
      r_started <= 1'b1;
    end
  end

  // Pixel index and bus address advance together on every accepted word.
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      r_pix_idx <= PW'(0);
      r_adr     <= BASE_ADDR;
    end else if (w_push) begin
      if (r_pix_idx == LAST_IDX) begin
        r_pix_idx <= PW'(0);
        r_adr     <= BASE_ADDR;
      end else begin
        r_pix_idx <= r_pix_idx + PW'(1);
        r_adr     <= r_adr + 32'd4;
      end
    end else begin
      r_pix_idx <= r_pix_idx;
      r_adr     <= r_adr;
    end
  end

  // FIFO storage; contents need no reset because count gates visibility.
  always_ff @(posedge pixel_clk) begin
    if (w_push && !pixel_rst) begin
      r_mem[r_wr_ptr] <= {w_sof, wshb_dat_sm[23:0]};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= CW'(0);
    end else begin
      r_wr_ptr <= w_push ? (r_wr_ptr + AW'(1)) : r_wr_ptr;
      r_rd_ptr <= w_pop  ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
      r_count  <= count_next(w_push, w_pop, r_count);
    end
  end

  // Starvation only counts once streaming has started, and is sticky until reset.
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      r_popped    <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_popped    <= r_popped | w_pop;
      r_underflow <= r_underflow | (pix_ready && w_empty && r_popped);
    end
  end

  assign wshb_cyc  = (r_state == S_REQ);
  assign wshb_stb  = (r_state == S_REQ);
  assign wshb_we   = 1'b0;
  assign wshb_sel  = 4'hF;
  assign wshb_adr  = r_adr;

  assign {pix_sof, pix_rgb} = r_mem[r_rd_ptr];
  assign pix_valid = !w_empty;
  assign underflow = r_underflow;

endmodule

// File: doc/fb_fetch.md
FB_FETCH -- requirements
Module: fb_fetch

Interface
REQ-001 Parameter HDISP, default 800, pixels per line.
REQ-002 Parameter VDISP, default 480, lines per frame.
REQ-003 Parameter BASE_ADDR, default 32'h0, byte address of pixel 0.
REQ-004 Parameter FIFO_DEPTH, default 16, pixel buffer entries (power of 2, >=4).
REQ-005 pixel_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 pixel_rst  in  1  reset, synchronous, active-high.
REQ-007 wshb_cyc  out  1  Wishbone bus cycle.
REQ-008 wshb_stb  out  1  Wishbone strobe.
REQ-009 wshb_we  out  1  write enable, constant 0.
REQ-010 wshb_sel  out  4  byte select, constant 4'hF.
REQ-011 wshb_adr  out  32  byte address of current read.
REQ-012 wshb_dat_sm  in  32  read data; bits [23:0] = RGB.
REQ-013 wshb_ack  in  1  read acknowledge.
REQ-014 pix_rgb  out  24  pixel at FIFO head.
REQ-015 pix_sof  out  1  head pixel is pixel 0 of a frame.
REQ-016 pix_valid  out  1  FIFO not empty.
REQ-017 pix_ready  in  1  consumer (video timing stage) takes head pixel.
REQ-018 underflow  out  1  sticky: consumer starved after streaming began.

Function
REQ-019 FSM states IDLE, REQ; wshb_cyc = wshb_stb = 1 exactly in REQ.
REQ-020 IDLE -> REQ when fifo count + 1 <= FIFO_DEPTH - 1 (at least two free entries, covering the in-flight word); otherwise stay IDLE.
REQ-021 In REQ, wshb_adr and wshb_stb are held stable until wshb_ack; only one read is outstanding.
REQ-022 On wshb_ack in REQ: push {sof, wshb_dat_sm[23:0]} into FIFO the same edge; advance pixel index; REQ -> IDLE.
REQ-023 wshb_adr = BASE_ADDR + 4*pix_idx; pix_idx runs 0..HDISP*VDISP-1, then wraps to 0; frames fetched back-to-back without gap.
REQ-024 sof bit stored with a word is 1 iff its pix_idx is 0.
REQ-025 Pop occurs on the edge where pix_valid && pix_ready; pix_ready while empty is ignored (no pop, count unchanged).
REQ-026 Push and pop on the same edge leave count unchanged; data ordering strictly FIFO.
REQ-027 FIFO never overflows: a push never occurs with count == FIFO_DEPTH (guaranteed by REQ-020; the bench checks it).
REQ-028 pix_rgb / pix_sof are combinational from FIFO head; undefined content is ignored while pix_valid = 0.
REQ-029 Pop-to-next-head latency is 0 cycles: a new head is visible the cycle after pop.
REQ-030 underflow sets when pix_ready = 1, pix_valid = 0 and at least one pixel has been popped since reset; it clears only on reset.
REQ-031 wshb_ack outside REQ is ignored.
REQ-032 Counter widths: pix_idx width $clog2(HDISP*VDISP); count width $clog2(FIFO_DEPTH)+1.

Reset
REQ-033 While pixel_rst = 1 at an edge: FSM = IDLE, pix_idx = 0, FIFO emptied (count 0), underflow = 0, popped-flag = 0.
REQ-034 Reset values: wshb_cyc = 0, wshb_stb = 0, wshb_we = 0, wshb_sel = 4'hF, wshb_adr = BASE_ADDR, pix_valid = 0, underflow = 0.
REQ-035 Reset during REQ abandons the transfer: cyc/stb low next cycle; a late ack is ignored; fetch restarts at pixel 0 with sof.
REQ-036 First request is issued no earlier than the second edge after reset deasserts.

Verification
REQ-037 Reset, ack always next cycle, pix_ready = 0 -> exactly FIFO_DEPTH-1 reads at adr 0,4,8,...; then cyc stays 0, pix_valid = 1, first head sof = 1.
REQ-038 HDISP=4, VDISP=2, memory word = address, pix_ready = 1 -> pix_rgb sequence 0,4,...,28,0,4,...; sof = 1 only on the 0 entries; wshb_adr wraps 28 -> 0.
REQ-039 Ack delayed by random 0-5 cycles -> adr/stb stable while waiting; output stream is unchanged from REQ-038, with no lost or duplicated pixel.
REQ-040 Full FIFO, then pix_ready pulsed on one cycle while an ack lands on the same edge -> count unchanged; order preserved; no overflow.
REQ-041 After 10 pixels popped, ack withheld with pix_ready = 1 -> underflow rises once FIFO empties and stays 1 until pixel_rst.
REQ-042 pixel_rst asserted mid-REQ at pix_idx 5, then ack returned one cycle later -> ack ignored; pix_valid = 0; next read at BASE_ADDR; first popped pixel has sof = 1.
